// File: rtl/ram16k_dma_pkg.sv
// ram16k_dma_pkg: shared types and constants for the RAM16k block-move engine.
//   state_e   - FSM state encoding (IDLE/READ/WRITE/DONE)
//   MODE_COPY - copy src -> dst
//   MODE_FILL - fill dst with a constant word
package ram16k_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/ram16k_dma.sv
// ram16k_dma: memory-initiator engine that drives a RAM16k port to block-copy
// or block-fill word regions.
//
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   start               - request pulse, sampled only in IDLE
//   mode                - 0 copy src->dst, 1 fill dst with fill_val
//   src_addr, dst_addr  - base word addresses (src ignored in fill)
//   len                 - word count, 0 = no-op
//   fill_val            - fill word
//   mem_out             - RAM16k read data (combinational from mem_addr)
//   mem_in, mem_addr,
//   mem_load            - RAM16k write data / address / write enable
//   busy                - high in READ/WRITE
//   done                - one-cycle completion pulse
module ram16k_dma
  import ram16k_dma_pkg::*;
#(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] len,
  input  logic [DATA_W-1:0] fill_val,
  input  logic [DATA_W-1:0] mem_out,
  output logic [DATA_W-1:0] mem_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_load,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] buf_q, buf_d;

  logic [DATA_W-1:0] mem_in_q, mem_in_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_load_q, mem_load_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    fill_d  = fill_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    buf_d   = buf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d = mode;
          fill_d = fill_val;
          src_d  = src_addr;
          dst_d  = dst_addr;
          rem_d  = len;
          if (len == '0)              state_d = ST_DONE;
          else if (mode == MODE_FILL) state_d = ST_WRITE;
          else                        state_d = ST_READ;
        end
      end
      ST_READ: begin
        buf_d   = mem_out;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        src_d = src_q + ADDR_W'(1);
        dst_d = dst_q + ADDR_W'(1);
        rem_d = rem_q - ADDR_W'(1);
        if (rem_q == ADDR_W'(1))      state_d = ST_DONE;
        else if (mode_q == MODE_FILL) state_d = ST_WRITE;
        else                          state_d = ST_READ;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state/pointers and registered, so the
    // flopped outputs equal a Moore decode of the registered state.
    mem_in_d   = '0;
    mem_addr_d = '0;
    mem_load_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    unique case (state_d)
      ST_READ: begin
        mem_addr_d = src_d;
        busy_d     = 1'b1;
      end
      ST_WRITE: begin
        mem_addr_d = dst_d;
        mem_in_d   = (mode_d == MODE_FILL) ? fill_d : buf_d;
        mem_load_d = 1'b1;
        busy_d     = 1'b1;
      end
      ST_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mode_q     <= 1'b0;
      fill_q     <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      rem_q      <= '0;
      buf_q      <= '0;
      mem_in_q   <= '0;
      mem_addr_q <= '0;
      mem_load_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      fill_q     <= fill_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      rem_q      <= rem_d;
      buf_q      <= buf_d;
      mem_in_q   <= mem_in_d;
      mem_addr_q <= mem_addr_d;
      mem_load_q <= mem_load_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign mem_in   = mem_in_q;
  assign mem_addr = mem_addr_q;
  assign mem_load = mem_load_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_ram16k_dma.sv
// tb_ram16k_dma: self-checking bench for ram16k_dma with a behavioural RAM16k
// responder. Expected writes are queued when an operation is launched and
// popped as the DUT asserts mem_load.
module tb_ram16k_dma;

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 16;
  localparam logic [AW-1:0] AMASK = '1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          mode;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [AW-1:0] len;
  logic [DW-1:0] fill_val;
  logic [DW-1:0] mem_out;
  logic [DW-1:0] mem_in;
  logic [AW-1:0] mem_addr;
  logic          mem_load;
  logic          busy;
  logic          done;

  // Bench-side preload port into the RAM model.
  logic          tb_we;
  logic [AW-1:0] tb_addr;
  logic [DW-1:0] tb_data;

  logic [DW-1:0] ram   [0:(1<<AW)-1];
  logic [DW-1:0] model [0:(1<<AW)-1];

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  done_cnt = 0;
  int  busy_cnt = 0;
  int  load_cnt = 0;

  always #5 clk = ~clk;

  ram16k_dma #(.ADDR_W(AW), .DATA_W(DW)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mode     (mode),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .fill_val (fill_val),
    .mem_out  (mem_out),
    .mem_in   (mem_in),
    .mem_addr (mem_addr),
    .mem_load (mem_load),
    .busy     (busy),
    .done     (done)
  );

  // RAM16k responder: combinational read, write on rising edge.
  assign mem_out = ram[mem_addr];
  always @(posedge clk) begin
    if (tb_we)         ram[tb_addr]  <= tb_data;
    else if (mem_load) ram[mem_addr] <= mem_in;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (busy) busy_cnt++;
    if (mem_load) begin
      wr_t e;
      load_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e.addr));
        check("wr_data", 32'(mem_in), 32'(e.data));
      end
    end
  end

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_addr = a; tb_data = d;
    @(negedge clk);
    tb_we = 1'b0;
    model[a] = d;
  endtask

  // Queue the writes an operation should produce, advancing the shadow model
  // word by word so overlapping copies smear exactly as the hardware does.
  task automatic expect_op(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                           input int n, input logic [DW-1:0] f);
    logic [AW-1:0] sa, da;
    logic [DW-1:0] w;
    sa = s; da = d;
    for (int i = 0; i < n; i++) begin
      w = m ? f : model[sa];
      model[da] = w;
      exp_q.push_back('{addr: da, data: w});
      sa = (sa + AW'(1)) & AMASK;
      da = (da + AW'(1)) & AMASK;
    end
  endtask

  task automatic run_op(input string tag, input logic m, input logic [AW-1:0] s,
                        input logic [AW-1:0] d, input logic [AW-1:0] n,
                        input logic [DW-1:0] f, input int exp_lat, input bit mid_start);
    int cyc, d0, b0, l0;
    bit seen;
    expect_op(m, s, d, int'(n), f);
    @(negedge clk);
    d0 = done_cnt; b0 = busy_cnt; l0 = load_cnt;
    start = 1'b1; mode = m; src_addr = s; dst_addr = d; len = n; fill_val = f;
    @(posedge clk);
    #1;
    start = 1'b0; mode = ~m; src_addr = '1; dst_addr = '1; len = '1; fill_val = '1;
    cyc = 0; seen = 1'b0;
    while (cyc < 200 && !seen) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1'b1;
      if (mid_start && cyc == 2) begin
        start = 1'b1; mode = 1'b1; dst_addr = 14'h0500; len = 14'd5;
      end
      if (mid_start && cyc == 3) start = 1'b0;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    repeat (3) @(negedge clk);
    #1;
    check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_loads"}, 32'(load_cnt - l0), 32'(n));
    check({tag, "_busy_cycles"}, 32'(busy_cnt - b0), 32'(m ? int'(n) : 2 * int'(n)));
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < int'(n); i++) begin
      logic [AW-1:0] a;
      a = (d + AW'(i)) & AMASK;
      check({tag, "_readback"}, 32'(ram[a]), 32'(model[a]));
    end
  endtask

  initial begin
    int l0;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
    len = '0; fill_val = '0; tb_we = 1'b0; tb_addr = '0; tb_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_load", 32'(mem_load), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_in", 32'(mem_in), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill with a sentinel just past the region.
    poke(14'h0104, 16'hC0DE);
    run_op("fill", 1'b1, 14'h0000, 14'h0100, 14'd4, 16'hBEEF, 5, 1'b0);
    check("fill_untouched", 32'(ram[14'h0104]), 32'hC0DE);

    // Copy.
    poke(14'h0000, 16'h1111);
    poke(14'h0001, 16'h2222);
    poke(14'h0002, 16'h3333);
    poke(14'h2003, 16'h5555);
    run_op("copy", 1'b0, 14'h0000, 14'h2000, 14'd3, 16'hFFFF, 7, 1'b0);
    check("copy_untouched", 32'(ram[14'h2003]), 32'h5555);

    // Zero length.
    run_op("len0", 1'b0, 14'h0040, 14'h0080, 14'd0, 16'h0000, 1, 1'b0);

    // Wrap through the top of the address space.
    poke(14'h0002, 16'h7E7E);
    run_op("wrap", 1'b1, 14'h0000, 14'h3FFE, 14'd4, 16'h00AA, 5, 1'b0);
    check("wrap_untouched", 32'(ram[14'h0002]), 32'h7E7E);

    // Forward overlapping copy with an ignored mid-transfer start.
    poke(14'h0010, 16'h000A);
    poke(14'h0011, 16'h000B);
    poke(14'h0500, 16'h4242);
    run_op("overlap", 1'b0, 14'h0010, 14'h0011, 14'd2, 16'h0000, 5, 1'b1);
    check("overlap_0x12", 32'(ram[14'h0012]), 32'h000A);
    check("overlap_ignored", 32'(ram[14'h0500]), 32'h4242);

    // Reset during a fill: the third write commits, the DUT resets on that edge.
    poke(14'h0303, 16'h1234);
    expect_op(1'b1, 14'h0000, 14'h0300, 3, 16'h5A5A);
    @(negedge clk);
    l0 = load_cnt;
    start = 1'b1; mode = 1'b1; dst_addr = 14'h0300; len = 14'd8; fill_val = 16'h5A5A;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 20 && (load_cnt - l0) < 3; i++) begin
      @(negedge clk);
      #1;
    end
    check("rstmid_writes", 32'(load_cnt - l0), 32'd3);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rstmid_mem_load", 32'(mem_load), 32'd0);
    check("rstmid_mem_addr", 32'(mem_addr), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rstmid_total_writes", 32'(load_cnt - l0), 32'd3);
    check("rstmid_queue_empty", 32'(exp_q.size()), 32'd0);
    check("rstmid_word2", 32'(ram[14'h0302]), 32'h5A5A);
    check("rstmid_untouched", 32'(ram[14'h0303]), 32'h1234);
    run_op("after_rst", 1'b1, 14'h0000, 14'h0300, 14'd2, 16'h7777, 3, 1'b0);
    check("after_rst_untouched", 32'(ram[14'h0303]), 32'h1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
